// File: rtl/timer_pkg.sv
// Shared types, default timing constants and the seven-segment decoder for
// the MM:SS countdown timer.
package timer_pkg;

  localparam int unsigned DEF_TICK_DIV   = 32'd50_000_000;
  localparam int unsigned DEF_REPEAT_DIV = 32'd25_000_000;
  localparam int unsigned DEF_BLINK_ON   = 32'd10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef logic [3:0] digit_t;

  // Active-low segments, bit order gfedcba; non-BCD codes blank the display.
  function automatic logic [6:0] seg7(input digit_t d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One modulo-N BCD digit. Clear beats decrement beats increment; borrow_o and
// carry_o flag a wrap on this edge so digits can be chained.
module bcd_digit
  import timer_pkg::*;
#(
  parameter int unsigned N = 32'd10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr_i,
  input  logic   inc_i,
  input  logic   dec_i,
  output digit_t value_o,
  output logic   borrow_o,
  output logic   carry_o
);

  localparam digit_t MAX = digit_t'(N - 32'd1);

  digit_t value_q, value_d;

  // Next digit value.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = 4'd0;
    end else if (dec_i) begin
      value_d = (value_q == 4'd0) ? MAX : value_q - 4'd1;
    end else if (inc_i) begin
      value_d = (value_q == MAX) ? 4'd0 : value_q + 4'd1;
    end else begin
      value_d = value_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign borrow_o = dec_i && (value_q == 4'd0);
  assign carry_o  = inc_i && (value_q == MAX);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with key-driven editing, start/pause/acknowledge on
// KEY1, auto-repeat on held edit keys and a blinking expiry LED.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned REPEAT_DIV = DEF_REPEAT_DIV,
  parameter int unsigned BLINK_ON   = DEF_BLINK_ON
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SW1,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       KEY2,
  input  logic       KEY3,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       LED9,
  output logic       LED7
);

  localparam int unsigned PW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
  localparam int unsigned RW = (REPEAT_DIV > 32'd1) ? $clog2(REPEAT_DIV) : 32'd1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 32'd1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_DIV - 32'd1);
  // Synchronizer bit order {SW1, KEY3, KEY2, KEY1, KEY0}; KEY0 idles high.
  localparam logic [4:0] SYNC_IDLE = 5'b00001;

  logic [4:0]    sync1_q, sync2_q;
  logic          key1_prev_q;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] blink_q, blink_d;
  logic [RW-1:0] rep_q, rep_d;

  logic   clr_s, key1_edge_s, key2_s, key3_s, sw1_s;
  logic   zero_s, last_s, tick_s, dec_s, held_s, edit_en_s;
  logic   sec_inc_s, min_inc_s;
  logic   b0_s, b1_s, b2_s, c0_s, c2_s;
  logic [2:0] unused_roll_s;
  digit_t sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;

  // Input synchronizers and KEY1 edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= SYNC_IDLE;
      sync2_q     <= SYNC_IDLE;
      key1_prev_q <= 1'b0;
    end else begin
      sync1_q     <= {SW1, KEY3, KEY2, KEY1, KEY0};
      sync2_q     <= sync1_q;
      key1_prev_q <= sync2_q[1];
    end
  end

  assign clr_s       = ~sync2_q[0];
  assign key1_edge_s = sync2_q[1] & ~key1_prev_q;
  assign key2_s      = sync2_q[2];
  assign key3_s      = sync2_q[3];
  assign sw1_s       = sync2_q[4];

  assign zero_s = ({min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} == 16'h0000);
  assign last_s = ({min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} == 16'h0001);
  // A KEY1 edge in RUN pauses instead of consuming the tick on that edge.
  assign tick_s = (state_q == ST_RUN) && (presc_q == TICK_MAX) && !key1_edge_s && !clr_s;
  assign dec_s  = tick_s && !zero_s;

  assign held_s    = key2_s ^ key3_s;
  assign edit_en_s = sw1_s && !clr_s && held_s && (rep_q == {RW{1'b0}}) &&
                     ((state_q == ST_IDLE) || (state_q == ST_PAUSED));
  assign sec_inc_s = edit_en_s && key2_s;
  assign min_inc_s = edit_en_s && key3_s;

  // Next state.
  always_comb begin
    state_d = state_q;
    if (clr_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = (key1_edge_s && !zero_s) ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (key1_edge_s) begin
            state_d = ST_PAUSED;
          end else if (tick_s && (zero_s || last_s)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSED: state_d = key1_edge_s ? ST_RUN : ST_PAUSED;
        ST_DONE:   state_d = key1_edge_s ? ST_IDLE : ST_DONE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler, auto-repeat and blink counters.
  always_comb begin
    presc_d = presc_q;
    if (clr_s) begin
      presc_d = {PW{1'b0}};
    end else if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      presc_d = {PW{1'b0}};
    end else if (state_q == ST_RUN) begin
      presc_d = (presc_q == TICK_MAX) ? {PW{1'b0}} : presc_q + 1'b1;
    end else begin
      presc_d = presc_q;
    end

    rep_d = {RW{1'b0}};
    if (held_s) begin
      rep_d = (rep_q == REP_MAX) ? {RW{1'b0}} : rep_q + 1'b1;
    end else begin
      rep_d = {RW{1'b0}};
    end

    blink_d = (blink_q == TICK_MAX) ? {PW{1'b0}} : blink_q + 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= {PW{1'b0}};
      rep_q   <= {RW{1'b0}};
      blink_q <= {PW{1'b0}};
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rep_q   <= rep_d;
      blink_q <= blink_d;
    end
  end

  // Seconds never carry into minutes on an edit; only borrows chain across.
  bcd_digit #(.N(32'd10)) u_sec_ones (
    .clk(clk), .rst(rst), .clr_i(clr_s), .inc_i(sec_inc_s), .dec_i(dec_s),
    .value_o(sec_ones_s), .borrow_o(b0_s), .carry_o(c0_s)
  );
  bcd_digit #(.N(32'd6)) u_sec_tens (
    .clk(clk), .rst(rst), .clr_i(clr_s), .inc_i(c0_s), .dec_i(b0_s),
    .value_o(sec_tens_s), .borrow_o(b1_s), .carry_o(unused_roll_s[0])
  );
  bcd_digit #(.N(32'd10)) u_min_ones (
    .clk(clk), .rst(rst), .clr_i(clr_s), .inc_i(min_inc_s), .dec_i(b1_s),
    .value_o(min_ones_s), .borrow_o(b2_s), .carry_o(c2_s)
  );
  bcd_digit #(.N(32'd10)) u_min_tens (
    .clk(clk), .rst(rst), .clr_i(clr_s), .inc_i(c2_s), .dec_i(b2_s),
    .value_o(min_tens_s), .borrow_o(unused_roll_s[1]), .carry_o(unused_roll_s[2])
  );

  assign HEX0 = seg7(sec_ones_s);
  assign HEX1 = seg7(sec_tens_s);
  assign HEX2 = seg7(min_ones_s);
  assign HEX3 = seg7(min_tens_s);
  assign LED9 = (state_q == ST_RUN);
  assign LED7 = (state_q == ST_DONE) && (32'(blink_q) < BLINK_ON);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer against a seconds-count
// reference model that applies the timer rules per clock edge.
module tb_countdown_timer;

  localparam int TD = 4;
  localparam int RD = 8;
  localparam int BO = 1;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

  logic clk, rst, SW1, KEY0, KEY1, KEY2, KEY3;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic LED9, LED7;

  logic [6:0] SEG [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int checks = 0;
  int errors = 0;

  int m_state, m_mm, m_ss, m_phase, m_hold, m_cyc;
  logic [4:0] h1, h2;
  logic m_k1p;

  countdown_timer #(.TICK_DIV(TD), .REPEAT_DIV(RD), .BLINK_ON(BO)) dut (
    .clk(clk), .rst(rst), .SW1(SW1), .KEY0(KEY0), .KEY1(KEY1), .KEY2(KEY2), .KEY3(KEY3),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .LED9(LED9), .LED7(LED7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int mm, input int ss);
    chk(tag, 32'({HEX3, HEX2, HEX1, HEX0}),
        32'({SEG[mm/10], SEG[mm%10], SEG[ss/10], SEG[ss%10]}));
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_mm = 0; m_ss = 0; m_phase = 0; m_hold = 0; m_cyc = 0;
    h1 = 5'b00001; h2 = 5'b00001; m_k1p = 1'b0;
  endtask

  // One clock edge of the reference behaviour; inputs seen two edges late.
  task automatic model_update();
    bit k0, k1, k2, k3, sw, k1e, held, fire, can_edit;
    int tot, nxt;
    if (!rst) begin
      model_reset();
      return;
    end
    k0 = h2[0]; k1 = h2[1]; k2 = h2[2]; k3 = h2[3]; sw = h2[4];
    k1e = k1 && !m_k1p;
    held = k2 ^ k3;
    fire = held && ((m_hold % RD) == 0);
    m_hold = held ? m_hold + 1 : 0;
    m_cyc++;
    can_edit = k0 && sw && (m_state == S_IDLE || m_state == S_PAUSED);
    tot = m_mm * 60 + m_ss;
    nxt = m_state;
    if (!k0) begin
      nxt = S_IDLE; tot = 0; m_phase = 0;
    end else begin
      case (m_state)
        S_IDLE: if (k1e && tot != 0) begin nxt = S_RUN; m_phase = 0; end
        S_RUN: begin
          if (k1e) nxt = S_PAUSED;
          else if (m_phase == TD - 1) begin
            m_phase = 0;
            if (tot <= 1) begin tot = 0; nxt = S_DONE; end
            else tot = tot - 1;
          end else m_phase++;
        end
        S_PAUSED: if (k1e) begin nxt = S_RUN; m_phase = 0; end
        S_DONE: if (k1e) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
    m_mm = tot / 60;
    m_ss = tot % 60;
    if (can_edit && fire) begin
      if (k2) m_ss = (m_ss + 1) % 60;
      else    m_mm = (m_mm + 1) % 100;
    end
    m_state = nxt;
    m_k1p = k1;
    h2 = h1;
    h1 = {SW1, KEY3, KEY2, KEY1, KEY0};
  endtask

  task automatic compare_all();
    chk("hex0", 32'(HEX0), 32'(SEG[m_ss % 10]));
    chk("hex1", 32'(HEX1), 32'(SEG[m_ss / 10]));
    chk("hex2", 32'(HEX2), 32'(SEG[m_mm % 10]));
    chk("hex3", 32'(HEX3), 32'(SEG[m_mm / 10]));
    chk("led9", 32'(LED9), 32'(m_state == S_RUN));
    chk("led7", 32'(LED7), 32'((m_state == S_DONE) && ((m_cyc % TD) < BO)));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      #1;
      compare_all();
    end
  endtask

  task automatic tap(input int k);
    if (k == 1) KEY1 = 1'b1;
    else if (k == 2) KEY2 = 1'b1;
    else KEY3 = 1'b1;
    step(1);
    KEY1 = 1'b0; KEY2 = 1'b0; KEY3 = 1'b0;
    step(1);
  endtask

  task automatic wait_led9(input logic val, input int bound, output int n);
    n = 0;
    while (LED9 !== val && n < bound) begin
      step(1);
      n++;
    end
    chk("wait_led9", 32'(LED9), 32'(val));
  endtask

  initial begin
    int n, cnt;
    rst = 1'b1; SW1 = 1'b0; KEY0 = 1'b1; KEY1 = 1'b0; KEY2 = 1'b0; KEY3 = 1'b0;
    model_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    chk("rst_led9", 32'(LED9), 32'd0);
    chk("rst_led7", 32'(LED7), 32'd0);
    step(2);
    @(negedge clk) rst = 1'b1;
    step(3);

    // KEY1 at 00:00 is ignored.
    tap(1); step(4);
    chk("idle_start_zero", 32'(LED9), 32'd0);

    // Edit to 01:05, run to expiry.
    SW1 = 1'b1; step(3);
    tap(3);
    for (int i = 0; i < 5; i++) tap(2);
    step(3);
    chk_time("set_0105", 1, 5);
    SW1 = 1'b0; step(3);
    tap(1);
    wait_led9(1'b1, 10, n);
    step(20); chk_time("t_0100", 1, 0);
    step(4);  chk_time("t_0059", 0, 59);
    wait_led9(1'b0, 300, n);
    chk("done_latency", 32'(24 + n), 32'd260);
    chk_time("done_zero", 0, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (LED7 === 1'b1) cnt++;
    end
    chk("blink_count", 32'(cnt), 32'd2);

    // Edit ignored in DONE, KEY1 acknowledges.
    SW1 = 1'b1; step(3);
    tap(2); step(3);
    chk_time("done_edit", 0, 0);
    tap(1); step(4);
    chk("ack_led7", 32'(LED7), 32'd0);
    chk("ack_led9", 32'(LED9), 32'd0);

    // Pause at 00:30 and resume.
    for (int i = 0; i < 33; i++) tap(2);
    step(3);
    chk_time("set_0033", 0, 33);
    tap(1);
    wait_led9(1'b1, 10, n);
    step(12); chk_time("pre_pause", 0, 30);
    KEY1 = 1'b1; step(1); KEY1 = 1'b0; step(39);
    chk_time("paused_hold", 0, 30);
    chk("paused_led9", 32'(LED9), 32'd0);
    tap(1);
    wait_led9(1'b1, 10, n);
    step(3); chk_time("resume_hold", 0, 30);
    step(1); chk_time("resume_dec", 0, 29);

    // Edit ignored in RUN, then KEY0 clear.
    tap(3); step(4);
    chk("run_edit_min", 32'({HEX3, HEX2}), 32'({SEG[0], SEG[0]}));
    KEY0 = 1'b0; step(3);
    chk_time("key0_clear", 0, 0);
    chk("key0_led9", 32'(LED9), 32'd0);
    KEY0 = 1'b1; step(3);

    // Edit boundaries.
    KEY2 = 1'b1; step(17); KEY2 = 1'b0; step(3);
    chk_time("hold17", 0, 3);
    KEY3 = 1'b1; step(785); KEY3 = 1'b0; step(3);
    chk_time("min_99", 99, 3);
    for (int i = 0; i < 56; i++) tap(2);
    step(3); chk_time("sec_59", 99, 59);
    tap(2); step(3); chk_time("sec_wrap", 99, 0);
    KEY2 = 1'b1; KEY3 = 1'b1; step(10); KEY2 = 1'b0; KEY3 = 1'b0; step(3);
    chk_time("both_keys", 99, 0);
    tap(3); step(3); chk_time("min_wrap", 0, 0);

    // Asynchronous reset mid-RUN.
    for (int i = 0; i < 10; i++) tap(2);
    SW1 = 1'b0; step(3);
    tap(1);
    wait_led9(1'b1, 10, n);
    step(5);
    #2 rst = 1'b0;
    #1;
    chk_time("rst_run_hex", 0, 0);
    chk("rst_run_led9", 32'(LED9), 32'd0);
    chk("rst_run_led7", 32'(LED7), 32'd0);
    step(2);
    @(negedge clk) rst = 1'b1;
    step(20);
    chk("post_rst_led9", 32'(LED9), 32'd0);
    chk_time("post_rst_hex", 0, 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      KEY0 = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) KEY1 = ~KEY1;
      if ($urandom_range(0, 9) == 0)  KEY2 = ~KEY2;
      if ($urandom_range(0, 9) == 0)  KEY3 = ~KEY3;
      if ($urandom_range(0, 29) == 0) SW1 = ~SW1;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per 1 s countdown tick.
REQ-002 SHALL have parameter REPEAT_DIV, default 25_000_000, clk cycles per key auto-repeat step.
REQ-003 SHALL have parameter BLINK_ON, default 10_000_000, cycles LED7 is lit per tick period while expired.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports named as follows.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 SW1  input  1  edit enable, level.
REQ-008 KEY0  input  1  clear, active-low.
REQ-009 KEY1  input  1  start/stop/acknowledge, rising edge.
REQ-010 KEY2  input  1  add one second, level.
REQ-011 KEY3  input  1  add one minute, level.
REQ-012 HEX0..HEX3  output  7 each  seven-segment: sec ones, sec tens, min ones, min tens.
REQ-013 LED9  output  1  high while running.
REQ-014 LED7  output  1  blinks while expired.

Function
REQ-015 KEY0..KEY3 and SW1 SHALL pass a 2-flop synchronizer; all stated latencies are counted from synchronizer output.
REQ-016 Count SHALL be 4 BCD digits MM:SS, range 00:00-99:59; sec tens 0-5, all others 0-9.
REQ-017 FSM SHALL have states IDLE, RUN, PAUSED, DONE.
REQ-018 KEY1 edge SHALL cause: IDLE with nonzero count -> RUN; IDLE with 00:00 -> ignored; RUN -> PAUSED; PAUSED -> RUN; DONE -> IDLE.
REQ-019 Prescaler SHALL clear on every entry to RUN and SHALL count 0..TICK_DIV-1 only in RUN; tick = prescaler at TICK_DIV-1.
REQ-020 On each tick the count SHALL decrement by one second on the same edge, with BCD borrow through all digits (e.g. 10:00 -> 09:59).
REQ-021 A tick at 00:01 SHALL load 00:00 and enter DONE on the same edge.
REQ-022 Edits SHALL apply only when SW1=1 in IDLE or PAUSED; ignored in RUN and DONE.
REQ-023 A KEY2 or KEY3 edit SHALL apply on the press edge, then every REPEAT_DIV cycles while held.
REQ-024 KEY2 and KEY3 asserted together SHALL cause no edit.
REQ-025 A second edit SHALL wrap 59 -> 00 with no carry into minutes.
REQ-026 A minute edit SHALL wrap 99 -> 00.
REQ-027 KEY0 low SHALL load 00:00, enter IDLE and clear the prescaler on the next edge, from any state, overriding all other inputs.
REQ-028 LED9 SHALL equal (state==RUN).
REQ-029 LED7 SHALL be high in DONE during the first BLINK_ON cycles of each TICK_DIV period (free-running blink counter), and low elsewhere.
REQ-030 HEX outputs SHALL be combinational decodes of the registered digits.

Reset
REQ-031 rst low SHALL asynchronously force: state IDLE, count 00:00, prescaler 0, repeat counter 0, blink counter 0, synchronizers idle.
REQ-032 During reset, LED9 and LED7 SHALL be 0 and HEX0..HEX3 SHALL show "0".
REQ-033 Reset asserted mid-RUN SHALL leave no pending tick or edit after release.

Structure
REQ-034 Shared package timer_pkg SHALL hold the state enum, the BCD digit type and default TICK_DIV/REPEAT_DIV/BLINK_ON.
REQ-035 Sub-module bcd_digit SHALL implement one mod-N up/down digit with borrow-out.
REQ-036 countdown_timer SHALL instantiate four bcd_digit instances; the existing seven-segment decoder SHALL drive HEX.

Verification (TICK_DIV=4, REPEAT_DIV=8, BLINK_ON=1)
REQ-037 Reset -> HEX all "0", LED9=0, LED7=0; KEY1 edge with no edits -> state stays IDLE.
REQ-038 Edit one KEY3 tap and five KEY2 taps -> count 01:05; KEY1 -> LED9=1; count 01:00 -> 00:59 on one tick; DONE exactly 65*4 cycles after RUN entry; LED7 pulses 1 of every 4 cycles.
REQ-039 Pause at 00:30 for 40 cycles -> count holds 00:30 and LED9=0; resume -> next decrement 4 cycles later.
REQ-040 Sec 59 + KEY2 -> 00 with minutes unchanged; min 99 + KEY3 -> 00; KEY2 held 17 cycles -> +3 s; KEY2+KEY3 together -> no change.
REQ-041 KEY0 low mid-RUN -> 00:00/IDLE next edge; rst low mid-RUN -> immediate 00:00/IDLE, no tick after release until a new start.
REQ-042 Edit attempted in RUN or DONE -> ignored; KEY1 in DONE -> IDLE and LED7=0.
